// File: rtl/uart_rx_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_fifo_if
//  Purpose  : Serial line, FIFO pop handshake and status flags of the UART
//             receiver.
//  Revision : 1.0 - initial release
// ============================================================================
interface uart_rx_fifo_if;
    logic       rxSerial;
    logic       rxRdEn;
    logic [7:0] rxData;
    logic       rxFfEmpty;
    logic       rxFfFull;
    logic       frameErr;
    logic       overrun;

    // Receiver side: owns the FIFO and the status flags.
    modport master (
        input  rxSerial,
        input  rxRdEn,
        output rxData,
        output rxFfEmpty,
        output rxFfFull,
        output frameErr,
        output overrun
    );

    // Line driver / downstream consumer side.
    modport slave (
        output rxSerial,
        output rxRdEn,
        input  rxData,
        input  rxFfEmpty,
        input  rxFfFull,
        input  frameErr,
        input  overrun
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_fifo
//  Purpose  : 8N1 UART receiver feeding a circular receive FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16
) (
    input  wire logic      clk,
    input  wire logic      rstB,
    uart_rx_fifo_if.master bus
);

    localparam int c_cntW  = $clog2(CLKS_PER_BIT);
    localparam int c_addrW = $clog2(FIFO_DEPTH);

    localparam logic [c_cntW-1:0]  c_halfCnt = c_cntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_cntW-1:0]  c_lastCnt = c_cntW'(CLKS_PER_BIT - 1);
    localparam logic [c_cntW-1:0]  c_cntOne  = c_cntW'(1);
    localparam logic [c_addrW:0]   c_ptrOne  = (c_addrW + 1)'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rxState_t;

    rxState_t            r_state;
    logic                r_rxMeta;
    logic                r_rxS;
    logic [c_cntW-1:0]   r_cycleCnt;
    logic [2:0]          r_bitCnt;
    logic [7:0]          r_shift;
    logic                r_frameErr;
    logic                r_overrun;

    logic [7:0]          r_mem [FIFO_DEPTH];
    logic [c_addrW:0]    r_wrPtr;
    logic [c_addrW:0]    r_rdPtr;
    logic [7:0]          r_rxData;

    logic                w_empty;
    logic                w_full;
    logic                w_pop;
    logic                w_stopHit;
    logic                w_stopOk;
    logic                w_push;

    assign w_empty   = (r_wrPtr == r_rdPtr);
    assign w_full    = (r_wrPtr[c_addrW] != r_rdPtr[c_addrW]) &&
                       (r_wrPtr[c_addrW-1:0] == r_rdPtr[c_addrW-1:0]);
    assign w_pop     = bus.rxRdEn && !w_empty;
    assign w_stopHit = (r_state == STOP) && (r_cycleCnt == c_lastCnt);
    assign w_stopOk  = w_stopHit && r_rxS;
    // A pop in the stop-sample cycle frees a slot, so a full FIFO still accepts.
    assign w_push    = w_stopOk && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (!rstB) begin
            r_rxMeta <= 1'b1;
            r_rxS    <= 1'b1;
        end else begin
            r_rxMeta <= bus.rxSerial;
            r_rxS    <= r_rxMeta;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstB) begin
            r_state    <= IDLE;
            r_cycleCnt <= '0;
            r_bitCnt   <= 3'd0;
            r_shift    <= 8'h00;
            r_frameErr <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_frameErr <= w_stopHit && !r_rxS;
            r_overrun  <= w_stopOk && w_full && !w_pop;
            case (r_state)
                IDLE: begin
                    if (!r_rxS) begin
                        r_state    <= START;
                        r_cycleCnt <= '0;
                    end
                end
                START: begin
                    if (r_cycleCnt == c_halfCnt) begin
                        r_cycleCnt <= '0;
                        r_bitCnt   <= 3'd0;
                        r_state    <= r_rxS ? IDLE : DATA;
                    end else begin
                        r_cycleCnt <= r_cycleCnt + c_cntOne;
                    end
                end
                DATA: begin
                    if (r_cycleCnt == c_lastCnt) begin
                        r_cycleCnt <= '0;
                        r_shift    <= {r_rxS, r_shift[7:1]};
                        if (r_bitCnt == 3'd7) begin
                            r_state <= STOP;
                        end else begin
                            r_bitCnt <= r_bitCnt + 3'd1;
                        end
                    end else begin
                        r_cycleCnt <= r_cycleCnt + c_cntOne;
                    end
                end
                STOP: begin
                    // Leave mid stop bit so a back-to-back start edge is caught.
                    if (r_cycleCnt == c_lastCnt) begin
                        r_cycleCnt <= '0;
                        r_state    <= IDLE;
                    end else begin
                        r_cycleCnt <= r_cycleCnt + c_cntOne;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr[c_addrW-1:0]] <= r_shift;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstB) begin
            r_wrPtr  <= '0;
            r_rdPtr  <= '0;
            r_rxData <= 8'h00;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + c_ptrOne;
            end
            if (w_pop) begin
                r_rdPtr  <= r_rdPtr + c_ptrOne;
                r_rxData <= r_mem[r_rdPtr[c_addrW-1:0]];
            end
        end
    end

    assign bus.rxData    = r_rxData;
    assign bus.rxFfEmpty = w_empty;
    assign bus.rxFfFull  = w_full;
    assign bus.frameErr  = r_frameErr;
    assign bus.overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_fifo
//  Purpose  : Self-checking bench for uart_rx_fifo against a queue model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

    localparam int CLKS  = 16;
    localparam int DEPTH = 4;
    localparam int FRAME_CYCLES = 10 * CLKS;
    // Stop sample lands 155 edges after the start bit is driven:
    // 2 sync + 1 detect + 8 half-bit + 8*16 data + 16 stop count.
    localparam int STOP_SAMPLE_CYC = 154;

    logic clk  = 1'b0;
    logic rstB = 1'b0;

    uart_rx_fifo_if ifc ();

    uart_rx_fifo #(
        .CLKS_PER_BIT (CLKS),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk  (clk),
        .rstB (rstB),
        .bus  (ifc)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nErrors = 0;
    int feSeen  = 0;
    int ovSeen  = 0;
    int expFe   = 0;
    int expOv   = 0;

    logic [7:0] modelQ [$];
    logic [7:0] lastData = 8'h00;

    always @(negedge clk) begin
        if (ifc.frameErr === 1'b1) feSeen++;
        if (ifc.overrun === 1'b1) ovSeen++;
    end

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nErrors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkFlags(input string tag);
        checkEq({tag, " empty"}, 32'(ifc.rxFfEmpty), 32'(modelQ.size() == 0));
        checkEq({tag, " full"},  32'(ifc.rxFfFull),  32'(modelQ.size() == DEPTH));
        checkEq({tag, " frameErrs"}, 32'(feSeen), 32'(expFe));
        checkEq({tag, " overruns"},  32'(ovSeen), 32'(expOv));
    endtask

    // Drives one 8N1 frame; rstAt >= 0 pulses reset there and idles the line.
    task automatic driveFrame(input logic [7:0] data, input logic stopBit,
                              input bit popAtStop, input int rstAt);
        logic [9:0] bits;
        bit aborted;
        bits    = {stopBit, data, 1'b0};
        aborted = 1'b0;
        for (int c = 0; c < FRAME_CYCLES; c++) begin
            if (c == rstAt) begin
                rstB    = 1'b0;
                aborted = 1'b1;
            end else begin
                rstB = 1'b1;
            end
            ifc.rxSerial = aborted ? 1'b1 : bits[c / CLKS];
            ifc.rxRdEn   = popAtStop && (c == STOP_SAMPLE_CYC);
            @(posedge clk);
            #1;
        end
        rstB         = 1'b1;
        ifc.rxRdEn   = 1'b0;
        ifc.rxSerial = 1'b1;
    endtask

    task automatic sendFrame(input logic [7:0] data, input logic stopBit, input bit popAtStop);
        bit popped;
        popped = 1'b0;
        if (popAtStop && modelQ.size() > 0) begin
            lastData = modelQ.pop_front();
            popped   = 1'b1;
        end
        if (!stopBit)                   expFe++;
        else if (modelQ.size() < DEPTH) modelQ.push_back(data);
        else                            expOv++;
        driveFrame(data, stopBit, popAtStop, -1);
        // A low stop bit reads as a new start edge; let the glitch filter settle.
        if (!stopBit) idle(CLKS);
        checkFlags($sformatf("frame %02h", data));
        if (popped) checkEq("pop at stop data", 32'(ifc.rxData), 32'(lastData));
    endtask

    task automatic popCheck(input string tag);
        ifc.rxRdEn = 1'b1;
        @(posedge clk);
        #1;
        ifc.rxRdEn = 1'b0;
        if (modelQ.size() > 0) lastData = modelQ.pop_front();
        checkEq({tag, " data"}, 32'(ifc.rxData), 32'(lastData));
        checkFlags(tag);
    endtask

    initial begin
        ifc.rxSerial = 1'b1;
        ifc.rxRdEn   = 1'b0;
        rstB         = 1'b0;
        idle(3);
        rstB = 1'b1;
        checkEq("reset rxData", 32'(ifc.rxData), 32'h00);
        checkEq("reset frameErr", 32'(ifc.frameErr), 32'd0);
        checkEq("reset overrun", 32'(ifc.overrun), 32'd0);
        checkFlags("reset");
        idle(5);

        // Single frame
        sendFrame(8'hA5, 1'b1, 1'b0);
        popCheck("single pop");

        // Back-to-back with overrun
        for (int i = 1; i <= 5; i++) begin
            sendFrame(8'(i), 1'b1, 1'b0);
        end
        for (int i = 0; i < 4; i++) popCheck("b2b pop");

        // Framing error then a good frame
        sendFrame(8'h3C, 1'b0, 1'b0);
        sendFrame(8'h5A, 1'b1, 1'b0);
        popCheck("after ferr pop");

        // Start glitch
        ifc.rxSerial = 1'b0;
        idle(4);
        ifc.rxSerial = 1'b1;
        idle(40);
        checkFlags("glitch");
        sendFrame(8'hFF, 1'b1, 1'b0);
        popCheck("after glitch pop");

        // Simultaneous push and pop while full
        for (int i = 0; i < 4; i++) sendFrame(8'(8'h10 + i), 1'b1, 1'b0);
        sendFrame(8'h14, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) popCheck("full pushpop pop");

        // Reset during data bit 3, with a byte already queued
        sendFrame(8'h77, 1'b1, 1'b0);
        driveFrame(8'h96, 1'b1, 1'b0, 4 * CLKS + 6);
        modelQ.delete();
        lastData = 8'h00;
        checkEq("midreset rxData", 32'(ifc.rxData), 32'h00);
        checkFlags("midreset");
        popCheck("empty read");
        sendFrame(8'hC3, 1'b1, 1'b0);
        popCheck("after reset pop");

        // Randomized traffic
        for (int n = 0; n < 30; n++) begin
            logic [7:0] d;
            d = 8'($urandom_range(0, 255));
            sendFrame(d, ($urandom_range(0, 7) != 0), ($urandom_range(0, 3) == 0));
            for (int p = $urandom_range(0, 2); p > 0; p--) popCheck("rand pop");
            idle($urandom_range(0, 3));
        end
        while (modelQ.size() > 0) popCheck("drain pop");
        popCheck("final empty read");

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
`default_nettype wire
